// File: rtl/spi_slave.sv
// spi_slave: byte-oriented SPI target, all four CPOL/CPHA modes, oversampled in clk domain.
// Optional build macro SPI_SLAVE_MISO_TRISTATE_EN: miso floats (1'bz) while deselected.
module spi_slave (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       select,
  input  logic       mclk,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       done
);
  logic [1:0] sel_s, mclk_s, mosi_s;
  logic       mclk_d, sel_d, first;
  logic [2:0] cnt;
  logic [6:0] rx;
  logic [7:0] tx;
  logic       sel, mclk_edge, lead, sample, shift_e, sel_rise;
  assign sel       = sel_s[1];
  assign mclk_edge = mclk_s[1] != mclk_d;
  assign lead      = mclk_edge && (mclk_s[1] != cpol);
  assign sample    = cpha ? (mclk_edge && !lead) : lead;
  assign shift_e   = cpha ? lead : (mclk_edge && !lead);
  assign sel_rise  = sel && !sel_d;
  // two-flop synchronisers plus delayed copies for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_s  <= '0;
      mclk_s <= '0;
      mosi_s <= '0;
      mclk_d <= 1'b0;
      sel_d  <= 1'b0;
    end else begin
      sel_s  <= {sel_s[0], select};
      mclk_s <= {mclk_s[0], mclk};
      mosi_s <= {mosi_s[0], mosi};
      mclk_d <= mclk_s[1];
      sel_d  <= sel;
    end
  end
  // receive/transmit shifters; first marks that the next shift edge reloads din
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      rx    <= '0;
      dout  <= '0;
      done  <= 1'b0;
      tx    <= 8'hFF;
      first <= 1'b1;
    end else if (!sel) begin
      cnt   <= '0;
      done  <= 1'b0;
      tx    <= 8'hFF;
      first <= 1'b1;
    end else if (sel_rise) begin
      cnt   <= '0;
      done  <= 1'b0;
      tx    <= din;
      first <= cpha;
    end else begin
      done <= sample && (cnt == 3'd7);
      if (sample) begin
        rx  <= {rx[5:0], mosi_s[1]};
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          dout  <= {rx, mosi_s[1]};
          first <= 1'b1;
        end
      end
      if (shift_e) begin
        tx    <= first ? din : {tx[6:0], 1'b1};
        first <= 1'b0;
      end
    end
  end
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign miso = sel ? tx[7] : 1'bz;
`else
  assign miso = sel ? tx[7] : 1'b1;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master driving spi_slave in all modes with a parent echo model.
module tb_spi_slave;
  logic       clk = 1'b0, rst_n = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic       select = 1'b0, mclk = 1'b0, mosi = 1'b0, miso;
  logic [7:0] din = 8'h00, dout;
  logic       done;
  logic       echo = 1'b0;
  int         checks = 0, errors = 0, done_cnt = 0;
  logic [7:0] got;
  logic       miso_idle;

  spi_slave dut (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .select(select),
    .mclk(mclk), .mosi(mosi), .miso(miso), .din(din), .dout(dout), .done(done)
  );

  always #5 clk = ~clk;

  // count clk cycles with done high, so a stretched pulse shows up as extra counts
  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // parent model: answers each completed byte one clk after done
  always @(posedge clk) if (echo && done === 1'b1) din <= dout;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign miso_idle = 1'bz;
`else
  assign miso_idle = 1'b1;
`endif

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // master transfer of the top nbits of b, MSB first, 50 ns half period (10 clk per mclk)
  task automatic spi_xfer(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi = b[i];
        #50;
        r[i] = miso;
        mclk = ~cpol;
        #50;
        mclk = cpol;
      end else begin
        #50;
        mclk = ~cpol;
        mosi = b[i];
        #50;
        r[i] = miso;
        mclk = cpol;
      end
    end
    #50;
  endtask

  task automatic set_mode(input logic p, input logic h);
    select = 1'b0;
    wait_clks(5);
    cpol = p;
    cpha = h;
    mclk = p;
    wait_clks(5);
  endtask

  task automatic test_reset;
    wait_clks(3);
    checks++;
    if (dout !== 8'h00 || done !== 1'b0 || miso !== 1'b1) begin
      errors++;
      $display("FAIL reset: dout=%h done=%b miso=%b, required dout=00 done=0 miso=1", dout, done, miso);
    end
    rst_n = 1'b1;
    wait_clks(3);
  endtask

  task automatic test_mode0_single;
    int d0;
    set_mode(1'b0, 1'b0);
    din = 8'h22;
    select = 1'b1;
    wait_clks(5);
    d0 = done_cnt;
    spi_xfer(8'h11, 8, got);
    wait_clks(3);
    checks++;
    if (dout !== 8'h11) begin
      errors++;
      $display("FAIL mode0_dout: got %h, required 11", dout);
    end
    checks++;
    if (got !== 8'h22) begin
      errors++;
      $display("FAIL mode0_miso: master got %h, required 22", got);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL mode0_done: %0d done cycles, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] tx_b [3] = '{8'h11, 8'hAB, 8'h5C};
    logic [7:0] rx_b [3] = '{8'h22, 8'h11, 8'hAB};
    int d0;
    set_mode(1'b0, 1'b0);
    din = 8'h22;
    select = 1'b1;
    echo = 1'b1;
    wait_clks(5);
    d0 = done_cnt;
    for (int k = 0; k < 3; k++) begin
      spi_xfer(tx_b[k], 8, got);
      checks++;
      if (got !== rx_b[k]) begin
        errors++;
        $display("FAIL b2b_miso[%0d]: master got %h, required %h", k, got, rx_b[k]);
      end
    end
    wait_clks(3);
    echo = 1'b0;
    checks++;
    if (dout !== 8'h5C || done_cnt - d0 !== 3) begin
      errors++;
      $display("FAIL b2b_rx: dout=%h dones=%0d, required dout=5c dones=3", dout, done_cnt - d0);
    end
  endtask

  task automatic test_modes;
    for (int m = 1; m < 4; m++) begin
      int d0;
      set_mode(m[1], m[0]);
      din = 8'hA5;
      select = 1'b1;
      wait_clks(5);
      d0 = done_cnt;
      spi_xfer(8'h3C, 8, got);
      wait_clks(3);
      checks++;
      if (dout !== 8'h3C) begin
        errors++;
        $display("FAIL mode%0d_dout: got %h, required 3c", m, dout);
      end
      checks++;
      if (got !== 8'hA5) begin
        errors++;
        $display("FAIL mode%0d_miso: master got %h, required a5", m, got);
      end
      checks++;
      if (done_cnt - d0 !== 1) begin
        errors++;
        $display("FAIL mode%0d_done: %0d done cycles, required 1", m, done_cnt - d0);
      end
    end
  endtask

  task automatic test_deselect_partial;
    int d0;
    set_mode(1'b0, 1'b0);
    din = 8'h5A;
    select = 1'b1;
    wait_clks(5);
    d0 = done_cnt;
    spi_xfer(8'hFF, 5, got);
    select = 1'b0;
    wait_clks(5);
    checks++;
    if (done_cnt !== d0 || dout !== 8'h3C) begin
      errors++;
      $display("FAIL partial: dones=%0d dout=%h, required dones=0 dout=3c", done_cnt - d0, dout);
    end
    select = 1'b1;
    wait_clks(5);
    spi_xfer(8'h7E, 8, got);
    wait_clks(3);
    checks++;
    if (dout !== 8'h7E || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL reselect: dout=%h dones=%0d, required dout=7e dones=1", dout, done_cnt - d0);
    end
    checks++;
    if (got !== 8'h5A) begin
      errors++;
      $display("FAIL reselect_miso: master got %h, required 5a", got);
    end
  endtask

  task automatic test_reset_midbyte;
    spi_xfer(8'hC3, 3, got);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || dout !== 8'h00 || miso !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: done=%b dout=%h miso=%b, required 0 00 1", done, dout, miso);
    end
    wait_clks(3);
    rst_n = 1'b1;
    select = 1'b0;
    mclk = cpol;
    wait_clks(3);
  endtask

  task automatic test_idle;
    int d0;
    select = 1'b0;
    wait_clks(5);
    checks++;
    if (miso !== miso_idle) begin
      errors++;
      $display("FAIL idle_miso: got %b, required %b", miso, miso_idle);
    end
    d0 = done_cnt;
    for (int i = 0; i < 16; i++) begin
      mosi = i[0];
      #50 mclk = ~mclk;
    end
    wait_clks(5);
    checks++;
    if (done_cnt !== d0 || miso !== miso_idle) begin
      errors++;
      $display("FAIL idle_done: dones=%0d miso=%b, required dones=0 miso=%b", done_cnt - d0, miso, miso_idle);
    end
  endtask

  initial begin
    test_reset;
    test_mode0_single;
    test_back_to_back;
    test_modes;
    test_deselect_partial;
    test_reset_midbyte;
    test_idle;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
